// File: rtl/accum_table_seq.sv
// Write-address sequencer for the output accumulator table: counts systolic-array
// output rows through row/column tiles and issues one registered table write per accepted row.
module accum_table_seq #(
    parameter int MAX_OUT_ROWS = 128,
    parameter int MAX_OUT_COLS = 128,
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16,
    localparam int NRT  = MAX_OUT_ROWS / SYS_ARR_ROWS,
    localparam int NCT  = MAX_OUT_COLS / SYS_ARR_COLS,
    localparam int NACC = MAX_OUT_ROWS * NCT,
    localparam int RT_W = (NRT > 1) ? $clog2(NRT) : 1,
    localparam int CT_W = (NCT > 1) ? $clog2(NCT) : 1,
    localparam int SR_W = (SYS_ARR_ROWS > 1) ? $clog2(SYS_ARR_ROWS) : 1,
    localparam int AW   = (NACC > 1) ? $clog2(NACC) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [RT_W-1:0] cfg_row_tiles_m1,
    input  logic [CT_W-1:0] cfg_col_tiles_m1,
    input  logic            cfg_accum,
    input  logic            abort,
    input  logic            row_valid,
    output logic            row_ready,
    output logic [SR_W-1:0] sub_row,
    output logic [RT_W-1:0] submat_row_idx,
    output logic [CT_W-1:0] submat_col_idx,
    output logic [AW-1:0]   wr_addr,
    output logic            wr_en,
    output logic            accum_en,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [SR_W-1:0] SUB_ROW_MAX = SR_W'(SYS_ARR_ROWS - 1);

    state_t          state_q, state_d;
    logic [SR_W-1:0] sub_row_q, sub_row_d;
    logic [RT_W-1:0] row_idx_q, row_idx_d;
    logic [CT_W-1:0] col_idx_q, col_idx_d;
    logic [RT_W-1:0] cfg_rows_q, cfg_rows_d;
    logic [CT_W-1:0] cfg_cols_q, cfg_cols_d;
    logic            cfg_accum_q, cfg_accum_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic            wr_en_q, wr_en_d;
    logic            accum_en_q, accum_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic sub_wrap, row_wrap, last_row;

    assign sub_wrap = (sub_row_q == SUB_ROW_MAX);
    assign row_wrap = (row_idx_q == cfg_rows_q);
    assign last_row = sub_wrap && row_wrap && (col_idx_q == cfg_cols_q);

    // Abort must block acceptance in the same cycle, so ready cannot be registered.
    assign row_ready = (state_q == RUN) && !abort;

    always_comb begin
        state_d     = state_q;
        sub_row_d   = sub_row_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        cfg_rows_d  = cfg_rows_q;
        cfg_cols_d  = cfg_cols_q;
        cfg_accum_d = cfg_accum_q;
        wr_addr_d   = wr_addr_q;
        wr_en_d     = 1'b0;
        accum_en_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    cfg_rows_d  = cfg_row_tiles_m1;
                    cfg_cols_d  = cfg_col_tiles_m1;
                    cfg_accum_d = cfg_accum;
                    sub_row_d   = '0;
                    row_idx_d   = '0;
                    col_idx_d   = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d   = IDLE;
                    sub_row_d = '0;
                    row_idx_d = '0;
                    col_idx_d = '0;
                end else if (row_valid) begin
                    wr_en_d    = 1'b1;
                    accum_en_d = cfg_accum_q;
                    // Rows leave the array bottom-first, hence the reversed in-tile offset.
                    wr_addr_d  = AW'(int'(col_idx_q) * MAX_OUT_ROWS
                                     + int'(row_idx_q) * SYS_ARR_ROWS
                                     + (SYS_ARR_ROWS - 1 - int'(sub_row_q)));
                    if (sub_wrap) begin
                        sub_row_d = '0;
                        if (row_wrap) begin
                            row_idx_d = '0;
                            col_idx_d = (col_idx_q == cfg_cols_q) ? '0 : col_idx_q + CT_W'(1);
                        end else begin
                            row_idx_d = row_idx_q + RT_W'(1);
                        end
                    end else begin
                        sub_row_d = sub_row_q + SR_W'(1);
                    end
                    if (last_row) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sub_row_q   <= '0;
            row_idx_q   <= '0;
            col_idx_q   <= '0;
            cfg_rows_q  <= '0;
            cfg_cols_q  <= '0;
            cfg_accum_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            accum_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sub_row_q   <= sub_row_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            cfg_rows_q  <= cfg_rows_d;
            cfg_cols_q  <= cfg_cols_d;
            cfg_accum_q <= cfg_accum_d;
            wr_addr_q   <= wr_addr_d;
            wr_en_q     <= wr_en_d;
            accum_en_q  <= accum_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sub_row        = sub_row_q;
    assign submat_row_idx = row_idx_q;
    assign submat_col_idx = col_idx_q;
    assign wr_addr        = wr_addr_q;
    assign wr_en          = wr_en_q;
    assign accum_en       = accum_en_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_accum_table_seq.sv
// Scoreboard bench for accum_table_seq: stimulus queues expected table writes,
// a negedge monitor pops and compares them whenever wr_en is seen.
module tb_accum_table_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [2:0] cfg_row_tiles_m1 = '0;
    logic [2:0] cfg_col_tiles_m1 = '0;
    logic       cfg_accum = 1'b0;
    logic       abort = 1'b0;
    logic       row_valid = 1'b0;
    logic       row_ready;
    logic [3:0] sub_row;
    logic [2:0] submat_row_idx;
    logic [2:0] submat_col_idx;
    logic [9:0] wr_addr;
    logic       wr_en;
    logic       accum_en;
    logic       busy;
    logic       done;

    typedef struct {
        int addr;
        bit acc;
        bit dn;
    } exp_t;

    exp_t sb[$];
    int   seen[$];
    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;

    accum_table_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .cfg_row_tiles_m1(cfg_row_tiles_m1),
        .cfg_col_tiles_m1(cfg_col_tiles_m1),
        .cfg_accum(cfg_accum),
        .abort(abort),
        .row_valid(row_valid),
        .row_ready(row_ready),
        .sub_row(sub_row),
        .submat_row_idx(submat_row_idx),
        .submat_col_idx(submat_col_idx),
        .wr_addr(wr_addr),
        .wr_en(wr_en),
        .accum_en(accum_en),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Bottom-first address of the b-th accepted row, derived from the beat number alone.
    function automatic int model_addr(input int b, input int r);
        int sub = b % 16;
        int rt  = (b / 16) % (r + 1);
        int ct  = b / (16 * (r + 1));
        return ct * 128 + rt * 16 + 15 - sub;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit rv, input bit ab, input bit st);
        row_valid = rv;
        abort     = ab;
        start     = st;
        step();
        row_valid = 1'b0;
        abort     = 1'b0;
        start     = 1'b0;
    endtask

    task automatic start_job(input int r, input int c, input bit acc);
        cfg_row_tiles_m1 = 3'(r);
        cfg_col_tiles_m1 = 3'(c);
        cfg_accum        = acc;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("busy_after_start", int'(busy), 1);
        checkOutput("sub_row_after_start", int'(sub_row), 0);
    endtask

    task automatic issue_beat(input int b, input int r, input int n, input bit acc, input bit st);
        exp_t e;
        e.addr = model_addr(b, r);
        e.acc  = acc;
        e.dn   = (b == n - 1);
        sb.push_back(e);
        applyStimulus(1'b1, 1'b0, st);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 6 && done_seen == d0; i++) step();
        checkOutput("done_count", done_seen, d0 + 1);
        checkOutput("busy_after_done", int'(busy), 0);
    endtask

    task automatic run_job(input int r, input int c, input bit acc, input bit gap, input bit poke);
        int n = 16 * (r + 1) * (c + 1);
        int d0;
        start_job(r, c, acc);
        d0 = done_seen;
        for (int b = 0; b < n; b++) begin
            if (gap && b > 0) applyStimulus(1'b0, 1'b0, 1'b0);
            if (poke && b == 3) begin
                cfg_row_tiles_m1 = 3'd7;
                cfg_col_tiles_m1 = 3'd7;
                cfg_accum        = ~acc;
                issue_beat(b, r, n, acc, 1'b1);
                cfg_row_tiles_m1 = 3'(r);
                cfg_col_tiles_m1 = 3'(c);
                cfg_accum        = acc;
            end else begin
                issue_beat(b, r, n, acc, 1'b0);
            end
        end
        wait_done(d0);
    endtask

    // Monitor: every write must match the oldest queued expectation; done only rides on the last write.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wr_en) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_wr: got wr_addr %0d with nothing expected at %0t", wr_addr, $time);
                end else begin
                    e = sb.pop_front();
                    checkOutput("wr_addr", int'(wr_addr), e.addr);
                    checkOutput("accum_en", int'(accum_en), int'(e.acc));
                    checkOutput("done_with_wr", int'(done), int'(e.dn));
                    seen.push_back(int'(wr_addr));
                end
            end else begin
                checkOutput("accum_en_idle", int'(accum_en), 0);
                checkOutput("done_without_wr", int'(done), 0);
            end
            if (done) done_seen++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_wr_en", int'(wr_en), 0);
        checkOutput("rst_wr_addr", int'(wr_addr), 0);
        checkOutput("rst_row_ready", int'(row_ready), 0);
        checkOutput("rst_sub_row", int'(sub_row), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Rows offered in IDLE are ignored.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("idle_rows_busy", int'(busy), 0);
        checkOutput("idle_rows_sub_row", int'(sub_row), 0);

        // Single tile, back-to-back rows.
        seen.delete();
        run_job(0, 0, 1'b0, 1'b0, 1'b0);
        checkOutput("job1_writes", seen.size(), 16);
        checkOutput("job1_first_addr", seen[0], 15);
        checkOutput("job1_last_addr", seen[15], 0);

        // 2x2 tiles.
        seen.delete();
        run_job(1, 1, 1'b0, 1'b0, 1'b0);
        checkOutput("job2_writes", seen.size(), 64);
        checkOutput("job2_beat16", seen[16], 31);
        checkOutput("job2_beat32", seen[32], 143);
        checkOutput("job2_beat63", seen[63], 144);
        checkOutput("job2_end_col_idx", int'(submat_col_idx), 0);

        // Accumulate mode with a gap between every row.
        seen.delete();
        run_job(1, 0, 1'b1, 1'b1, 1'b0);
        checkOutput("job3_writes", seen.size(), 32);
        checkOutput("job3_beat16", seen[16], 31);

        // Start pulsed mid-job with different config must change nothing.
        run_job(0, 0, 1'b0, 1'b0, 1'b1);

        // Abort coincident with beat 5.
        start_job(0, 0, 1'b0);
        d0 = done_seen;
        for (int b = 0; b < 5; b++) issue_beat(b, 0, 16, 1'b0, 1'b0);
        row_valid = 1'b1;
        abort     = 1'b1;
        #1;
        checkOutput("abort_row_ready", int'(row_ready), 0);
        step();
        row_valid = 1'b0;
        abort     = 1'b0;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_sub_row", int'(sub_row), 0);
        step();
        step();
        checkOutput("abort_no_done", done_seen, d0);
        seen.delete();
        run_job(0, 0, 1'b0, 1'b0, 1'b0);
        checkOutput("after_abort_first_addr", seen[0], 15);

        // Reset asserted mid-job while beat 20 is offered.
        start_job(1, 1, 1'b1);
        for (int b = 0; b < 20; b++) issue_beat(b, 1, 64, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        row_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_wr_en", int'(wr_en), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_row_ready", int'(row_ready), 0);
        checkOutput("midrst_accum_en", int'(accum_en), 0);
        checkOutput("midrst_wr_addr", int'(wr_addr), 0);
        checkOutput("midrst_sub_row", int'(sub_row), 0);
        checkOutput("midrst_row_idx", int'(submat_row_idx), 0);
        checkOutput("midrst_col_idx", int'(submat_col_idx), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        row_valid = 1'b0;
        checkOutput("postrst_busy", int'(busy), 0);
        checkOutput("postrst_sub_row", int'(sub_row), 0);
        step();

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
